rotation_line_parser: RTL and testbench
=======================================

Name: rotation_line_parser

Overview:
- Upstream neighbour of the dial coprocessor: converts the UART receive byte stream of rotation records ("L68\n", "R48\r\n") into signed binary rotation amounts.
- Drives the coprocessor's din/din_valid directly: one dout_valid pulse per well-formed record, value sign-extended to the coprocessor input width.
- Also reports record and error counts so the host can cross-check the answer.

Parameters:
- WIDTH_DOUT, 128: output word width; matches coprocessor WIDTH_DIN.
- WIDTH_COMPUTE, 32: accumulator width, signed magnitude domain.
- MAX_DIGITS, 9: maximum decimal digits per record; must satisfy 10^MAX_DIGITS < 2^(WIDTH_COMPUTE-1).
- WIDTH_CNT, 16: width of rec_count and err_count.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous reset, active-low (sampled on clk rising edge; 0 = reset).
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle.
- dout  out  WIDTH_DOUT  signed rotation, two's complement, sign-extended from WIDTH_COMPUTE.
- dout_valid  out  1  one-cycle pulse when dout is updated.
- rec_count  out  WIDTH_CNT  records emitted since reset.
- err_count  out  WIDTH_CNT  malformed records since reset.
- busy  out  1  high while a record is partially received (state != IDLE).

Behaviour:
- Reset (rst==0 at a clk edge):
  - State to IDLE; accumulator, digit count and sign cleared.
  - dout=0, dout_valid=0, rec_count=0, err_count=0, busy=0.
  - A partial record in flight is dropped silently and not counted as an error.
- Processing only occurs on cycles with rx_valid=1; all other cycles hold state. There is no backpressure: every strobed byte is consumed.
- State IDLE:
  - 'L' (0x4C): sign=neg; clear acc and ndig; go to DIGITS.
  - 'R' (0x52): sign=pos; clear acc and ndig; go to DIGITS.
  - 0x0A, 0x0D, 0x20 are ignored and the state stays IDLE.
  - Any other byte: err_count+1; go to DISCARD.
  - Letters are uppercase only; 'l' and 'r' are errors.
- State DIGITS:
  - '0'..'9' with ndig<MAX_DIGITS: acc = acc*10 + (byte-0x30); ndig+1. Implement as (acc<<3)+(acc<<1)+d; no multiplier.
  - A digit with ndig==MAX_DIGITS: err_count+1; go to DISCARD.
  - 0x0D is ignored.
  - 0x0A with ndig==0: err_count+1; go to IDLE.
  - 0x0A with ndig>0: emit; go to IDLE.
  - Any other byte: err_count+1; go to DISCARD.
- State DISCARD: 0x0A returns to IDLE; all other bytes are ignored.
- Emit:
  - On the clk edge after the accepting '\n' cycle: dout = neg ? -acc : acc, sign-extended to WIDTH_DOUT; dout_valid=1 for exactly one cycle; rec_count+1 on the same edge.
  - Latency: 1 cycle from '\n' strobe to dout_valid.
  - dout holds its value between emits.
- Counters saturate at all-ones and do not wrap.
- Input rate: records are at least 3 bytes long, so emits are spaced at least 3 rx_valid strobes apart. This gives the downstream restoring loop its settle time at UART byte rates.
- Back-to-back strobes on consecutive cycles are supported: a 'L'/'R' arriving on the cycle dout_valid is high is accepted normally.
- "-0" ("L0\n") emits 0, not a negative zero.

Optional Feature:
- Macro: PARSER_MOD100_EN.
- Defined:
  - Accumulator keeps only the last two decimal digits: acc = (acc mod 10)*10 + d, using a tens/ones digit pair register.
  - Emitted magnitude is value mod 100 (0..99) before sign application.
  - MAX_DIGITS overflow checking is disabled; any digit count ≥1 is legal.
  - This bounds downstream wrap correction to one add/subtract of 100.
- Undefined: full-magnitude accumulation and the MAX_DIGITS rule apply as above.

Test Plan:
1. Bytes "L68\n" -> one dout_valid pulse 1 cycle after '\n'; dout = -68 (low 32 bits 0xFFFFFFBC, upper bits all ones); rec_count=1, err_count=0.
2. "R48\r\n" then "L0\n" on back-to-back cycles -> emits +48 (0x30) then 0; rec_count=2; no pulse for '\r'.
3. "L\n" then "R5\n" -> err_count=1; exactly one emit, dout=+5; rec_count=1.
4. "R12x4\nQ9\nR7\n" -> err_count=2; only emit is +7; busy low after each '\n'.
5. Without PARSER_MOD100_EN: "R1234567890\n" -> err_count=1, no emit. With it: "L1234\n" -> dout=-34 and "R100\n" -> dout=0.
6. rst=0 for one cycle after "R9", then "R3\n" -> dout=+3, rec_count=1, err_count=0; dout=0 and busy=0 during and immediately after reset.

Source files
------------

// File: rtl/rotation_line_parser.sv
// Rotation record parser: turns "L68\n" / "R48\r\n" byte streams into signed rotation words.
// Optional macro PARSER_MOD100_EN keeps only the last two decimal digits of each record.
module rotation_line_parser #(
  parameter int unsigned WIDTH_DOUT    = 128,
  parameter int unsigned WIDTH_COMPUTE = 32,
  parameter int unsigned MAX_DIGITS    = 9,
  parameter int unsigned WIDTH_CNT     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic [WIDTH_DOUT-1:0] dout,
  output logic                  dout_valid,
  output logic [WIDTH_CNT-1:0]  rec_count,
  output logic [WIDTH_CNT-1:0]  err_count,
  output logic                  busy
);

  localparam int unsigned NDIG_W = $clog2(MAX_DIGITS + 1);
  localparam logic [NDIG_W-1:0] MAX_NDIG = NDIG_W'(MAX_DIGITS);

  typedef enum logic [1:0] {
    IDLE,
    DIGITS,
    DISCARD
  } state_t;

  state_t                     state;
  logic                       neg;
  logic [NDIG_W-1:0]          ndig;
  logic                       is_digit;
  logic [3:0]                 digit;
  logic                       digit_ok;
  logic [WIDTH_COMPUTE-1:0]   mag;
  logic signed [WIDTH_COMPUTE-1:0] sval;

  // ASCII '0'..'9' carry the digit value in the low nibble
  assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
  assign digit    = rx_data[3:0];

`ifdef PARSER_MOD100_EN
  logic [3:0] tens;
  logic [3:0] ones;

  assign digit_ok = 1'b1;

  always_comb begin
    mag = (WIDTH_COMPUTE'(tens) << 3) + (WIDTH_COMPUTE'(tens) << 1) + WIDTH_COMPUTE'(ones);
  end
`else
  logic [WIDTH_COMPUTE-1:0] acc;

  assign digit_ok = (ndig < MAX_NDIG);
  assign mag      = acc;
`endif

  assign sval = neg ? -$signed(mag) : $signed(mag);
  assign busy = (state != IDLE);

  function automatic logic [WIDTH_CNT-1:0] sat_inc(input logic [WIDTH_CNT-1:0] c);
    return (c == '1) ? c : c + WIDTH_CNT'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      neg        <= 1'b0;
      ndig       <= '0;
`ifdef PARSER_MOD100_EN
      tens       <= '0;
      ones       <= '0;
`else
      acc        <= '0;
`endif
      dout       <= '0;
      dout_valid <= 1'b0;
      rec_count  <= '0;
      err_count  <= '0;
    end else begin
      dout_valid <= 1'b0;
      if (rx_valid) begin
        case (state)
          IDLE: begin
            if (rx_data == 8'h4C || rx_data == 8'h52) begin
              neg   <= (rx_data == 8'h4C);
              ndig  <= '0;
`ifdef PARSER_MOD100_EN
              tens  <= '0;
              ones  <= '0;
`else
              acc   <= '0;
`endif
              state <= DIGITS;
            end else if (rx_data != 8'h0A && rx_data != 8'h0D && rx_data != 8'h20) begin
              err_count <= sat_inc(err_count);
              state     <= DISCARD;
            end
          end

          DIGITS: begin
            if (is_digit) begin
              if (digit_ok) begin
`ifdef PARSER_MOD100_EN
                tens <= ones;
                ones <= digit;
`else
                acc  <= (acc << 3) + (acc << 1) + WIDTH_COMPUTE'(digit);
`endif
                // Saturating so the mod-100 build can take unbounded digit runs
                ndig <= (ndig < MAX_NDIG) ? ndig + NDIG_W'(1) : ndig;
              end else begin
                err_count <= sat_inc(err_count);
                state     <= DISCARD;
              end
            end else if (rx_data == 8'h0A) begin
              state <= IDLE;
              if (ndig == '0) begin
                err_count <= sat_inc(err_count);
              end else begin
                dout       <= WIDTH_DOUT'(sval);
                dout_valid <= 1'b1;
                rec_count  <= sat_inc(rec_count);
              end
            end else if (rx_data != 8'h0D) begin
              err_count <= sat_inc(err_count);
              state     <= DISCARD;
            end
          end

          DISCARD: begin
            if (rx_data == 8'h0A) state <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rotation_line_parser.sv
// Self-checking bench for rotation_line_parser: record table plus reset corner sequence.
module tb_rotation_line_parser;

  localparam int unsigned WD = 128;
  localparam int unsigned WC = 32;
  localparam int unsigned MD = 9;
  localparam int unsigned WN = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic [WD-1:0] dout;
  logic          dout_valid;
  logic [WN-1:0] rec_count;
  logic [WN-1:0] err_count;
  logic          busy;

  rotation_line_parser #(
    .WIDTH_DOUT(WD),
    .WIDTH_COMPUTE(WC),
    .MAX_DIGITS(MD),
    .WIDTH_CNT(WN)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .dout(dout),
    .dout_valid(dout_valid),
    .rec_count(rec_count),
    .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string s;
    bit    emit;
    int    val;
    int    errs;
  } vec_t;

  vec_t          vecs[13];
  logic [WD-1:0] exp_q[$];
  int            checks = 0;
  int            errors = 0;
  int            exp_rec = 0;
  int            exp_err = 0;

  task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Byte is presented just after a rising edge and consumed at the next one
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_data  = '0;
  endtask

  task automatic send_rec(input string s, input bit emit, input int val, input int errs);
    for (int i = 0; i < s.len(); i++) begin
      if (emit && i == s.len() - 1) exp_q.push_back(WD'(val));
      send_byte(s[i]);
    end
    exp_err += errs;
    if (emit) exp_rec++;
    check({"valid_after_lf ", s}, WD'(dout_valid), WD'(emit));
    check("busy_after_lf", WD'(busy), '0);
    check("rec_count", WD'(rec_count), WD'(exp_rec));
    check("err_count", WD'(err_count), WD'(exp_err));
  endtask

  always @(negedge clk) begin
    if (rst && dout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_emit: got dout %h expected no pulse", dout);
      end else begin
        check("dout", dout, exp_q.pop_front());
      end
    end
  end

  initial begin
    vecs[0]  = '{"L68\n",           1'b1, -68,        0};
    vecs[1]  = '{"R48\015\n",       1'b1, 48,         0};
    vecs[2]  = '{"L0\n",            1'b1, 0,          0};
    vecs[3]  = '{"L\n",             1'b0, 0,          1};
    vecs[4]  = '{"R5\n",            1'b1, 5,          0};
    vecs[5]  = '{"R12x4\n",         1'b0, 0,          1};
    vecs[6]  = '{"Q9\n",            1'b0, 0,          1};
    vecs[7]  = '{"R7\n",            1'b1, 7,          0};
    vecs[8]  = '{" \015\nl5\n",     1'b0, 0,          1};
`ifdef PARSER_MOD100_EN
    vecs[9]  = '{"R999999999\n",    1'b1, 99,         0};
    vecs[10] = '{"R1234567890\n",   1'b1, 90,         0};
    vecs[11] = '{"L1234\n",         1'b1, -34,        0};
    vecs[12] = '{"R100\n",          1'b1, 0,          0};
`else
    vecs[9]  = '{"R999999999\n",    1'b1, 999999999,  0};
    vecs[10] = '{"R1234567890\n",   1'b0, 0,          1};
    vecs[11] = '{"L1234\n",         1'b1, -1234,      0};
    vecs[12] = '{"R100\n",          1'b1, 100,        0};
`endif

    repeat (2) @(posedge clk);
    #1;
    check("reset_dout", dout, '0);
    check("reset_valid", WD'(dout_valid), '0);
    check("reset_busy", WD'(busy), '0);
    check("reset_rec", WD'(rec_count), '0);
    check("reset_err", WD'(err_count), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Records go back-to-back, so a letter lands on the cycle dout_valid is high
    for (int i = 0; i < 13; i++) begin
      send_rec(vecs[i].s, vecs[i].emit, vecs[i].val, vecs[i].errs);
    end
    repeat (3) @(posedge clk);
    #1;
    check("dout_holds", dout, WD'(vecs[12].val));
    check("valid_low_idle", WD'(dout_valid), '0);

    // Partial record dropped by reset, no error counted
    send_byte(8'h52);
    send_byte(8'h39);
    check("busy_mid_record", WD'(busy), WD'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dout", dout, '0);
    check("rst_busy", WD'(busy), '0);
    check("rst_rec", WD'(rec_count), '0);
    check("rst_err", WD'(err_count), '0);
    check("rst_valid", WD'(dout_valid), '0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_busy", WD'(busy), '0);
    check("post_rst_dout", dout, '0);
    exp_rec = 0;
    exp_err = 0;
    send_rec("R3\n", 1'b1, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", WD'(exp_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
